fifo_pkt_arbiter: RTL and testbench
===================================

# fifo_pkt_arbiter

- Packet-aware round-robin arbiter that drains NUM_PORTS flit FIFOs into one output link of the fabric port.
- Drives each FIFO's read enable and uses the FIFO status flags (empty, almost-empty, next-is-tail) to hold ownership until a tail flit is popped.
- Never pops an empty FIFO.
- Meters the output with a credit counter tracking downstream buffer space.

## Interface
- NUM_PORTS, 4: number of source FIFOs (2..16).
- WIDTH, 36: flit width; bit WIDTH-1 valid, WIDTH-2 head, WIDTH-3 tail.
- CREDITS, 8: downstream buffer depth; credit counter width $clog2(CREDITS+1).
- Reset: preset_full, asynchronous, active-high. Clock: clk.
- clk  in  1  clock.
- preset_full  in  1  asynchronous active-high reset.
- f_empty  in  NUM_PORTS  per-FIFO empty flag.
- f_almost_empty  in  NUM_PORTS  per-FIFO flag, high when the FIFO holds 1 or fewer words.
- f_next_is_tail  in  NUM_PORTS  per-FIFO tail bit of the current head word.
- f_data  in  NUM_PORTS*WIDTH  FIFO read data; port p at [p*WIDTH +: WIDTH]; valid the cycle after its read.
- f_read_en  out  NUM_PORTS  one-hot FIFO pop, combinational.
- i_credit_return  in  1  one downstream slot freed.
- o_data  out  WIDTH  output flit.
- o_valid  out  1  o_data valid.
- o_grant  out  NUM_PORTS  one-hot current owner, registered.
- o_busy  out  1  packet in flight (state != IDLE).

## Operation
- States:
  - IDLE: no owner.
  - SEND: owner popping.
  - STALL: owner held, no pop this cycle.
- IDLE → SEND:
  - Select the first port p with f_empty[p]=0, searching rr_ptr+1 upward with wrap.
  - Register o_grant=p the next cycle. First pop happens in SEND.
- Pop rule in SEND/STALL. Assert f_read_en[g] only if all of the following hold:
  - f_empty[g]=0;
  - credits>0;
  - no pop of g in the previous cycle while f_almost_empty[g] was 1 (single-word bubble rule).
- Any pop condition false → STALL. All true → SEND.
- f_next_is_tail[g], sampled in the pop cycle, is the tail bit of the popped flit.
- Tail popped → next state IDLE, rr_ptr←g, o_grant←0.
- Credits:
  - Reset to CREDITS.
  - Pop: -1. i_credit_return: +1. Both in the same cycle: unchanged.
  - Return at CREDITS saturates (ignored).
- Output: o_data←f_data[g_d], o_valid←1 one cycle after the pop, where g_d is the grant registered at pop time.
- Never assert two read enables at once.
- Never assert a read enable in IDLE or on an unowned port.

## Timing
- Reset values:
  - f_read_en=0, o_valid=0, o_data=0, o_grant=0, o_busy=0.
  - credits=CREDITS, rr_ptr=NUM_PORTS-1, so port 0 wins first.
- Latency:
  - Request to grant: 1 cycle (IDLE→SEND).
  - Pop to o_valid: 1 cycle.
- Throughput: 1 flit/cycle while f_almost_empty[g]=0 and credits>0.
- Inter-packet gap: at least one IDLE cycle after each tail pop.
- Single-word FIFO: pop at t, no pop at t+1, re-evaluate at t+2.
- Credits=0: pop suppressed that cycle. A return at t allows a pop at t+1.
- Owner empties mid-packet: hold grant in STALL indefinitely; other ports are not served.
- preset_full asserted mid-packet: all state and outputs return to reset values immediately. A pending o_valid is dropped.

## Configuration
- FIFO_ARB_PKT_LOCK_EN defined: packet lock as described above; the grant is released only on a tail pop.
- FIFO_ARB_PKT_LOCK_EN undefined: flit-level round robin.
  - Grant released after every pop regardless of f_next_is_tail.
  - rr_ptr updated per flit.
  - f_next_is_tail ignored.

## Test plan
- Reset, then FIFO0 holds a 3-flit packet (tail on flit 3), CREDITS=8:
  - f_read_en[0] high 3 consecutive cycles;
  - o_valid high 3 cycles, one cycle later;
  - back to IDLE;
  - credits=5.
- FIFO1 and FIFO2 each hold a 2-flit packet, rr_ptr=0:
  - FIFO1 fully drained before FIFO2;
  - one IDLE cycle between the packets;
  - no interleaving.
- FIFO0 holds 1 flit of a 2-flit packet, second flit arrives 4 cycles later:
  - one pop;
  - STALL until f_empty[0]=0;
  - second pop, then IDLE;
  - FIFO3 packet meanwhile stays unserved.
- CREDITS=2, 4-flit packet, no returns:
  - 2 pops, then STALL.
  - Pulse i_credit_return at t: pop at t+1.
  - Return coincident with a pop leaves credits unchanged.
- Assert preset_full during flit 2 of 4:
  - o_valid=0 and f_read_en=0 that cycle;
  - credits=CREDITS;
  - port 0 wins next.
- Without FIFO_ARB_PKT_LOCK_EN, FIFO0 and FIFO1 each hold 2-flit packets: pops alternate 0,1,0,1.

Source files
------------

// File: rtl/fifo_pkt_arbiter.sv
// fifo_pkt_arbiter: credit-metered round-robin drain of NUM_PORTS flit FIFOs into one link.
// Define FIFO_ARB_PKT_LOCK_EN to hold ownership until a tail pop; otherwise the grant is released after every flit.
module fifo_pkt_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 36,
    parameter int CREDITS   = 8
) (
    input  logic                       clk,
    input  logic                       preset_full,
    input  logic [NUM_PORTS-1:0]       f_empty,
    input  logic [NUM_PORTS-1:0]       f_almost_empty,
    input  logic [NUM_PORTS-1:0]       f_next_is_tail,
    input  logic [NUM_PORTS*WIDTH-1:0] f_data,
    output logic [NUM_PORTS-1:0]       f_read_en,
    input  logic                       i_credit_return,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic [NUM_PORTS-1:0]       o_grant,
    output logic                       o_busy
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = $clog2(CREDITS + 1);
`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr, g, g_d, pick;
    logic [CW-1:0] credits;
    logic          found, bubble, pop, rel;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p, input int i);
        return PW'((int'(p) + i) % NUM_PORTS);
    endfunction

    // Descending scan so the nearest non-empty port after rr_ptr is the last write.
    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_PORTS; i >= 1; i--)
            if (!f_empty[nxt(rr_ptr, i)]) pick = nxt(rr_ptr, i);
    end

    // A pop made while the FIFO held one word forces a one-cycle bubble so its flags can settle.
    assign found     = |(~f_empty);
    assign pop       = state != IDLE && !f_empty[g] && credits != '0 && !bubble;
    assign rel       = f_next_is_tail[g] | !LOCK;
    assign f_read_en = pop ? o_grant : '0;
    assign o_busy    = state != IDLE;
    assign o_data    = o_valid ? f_data[int'(g_d)*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clk or posedge preset_full) begin
        if (preset_full) begin
            state   <= IDLE;
            o_grant <= '0;
            g       <= '0;
            g_d     <= '0;
            rr_ptr  <= PW'(NUM_PORTS - 1);
            credits <= CW'(CREDITS);
            bubble  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= pop;
            bubble  <= pop && f_almost_empty[g];
            g_d     <= pop ? g : g_d;
            credits <= credits - CW'(pop) + CW'(i_credit_return && (pop || credits != CW'(CREDITS)));
            if (state == IDLE) begin
                state   <= found ? SEND : IDLE;
                o_grant <= found ? NUM_PORTS'(1) << pick : '0;
                g       <= pick;
            end else if (pop && rel) begin
                state   <= IDLE;
                o_grant <= '0;
                rr_ptr  <= g;
            end else begin
                state <= pop ? SEND : STALL;
            end
        end
    end
endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// tb_fifo_pkt_arbiter: FIFO models, pop log and o_data scoreboard around fifo_pkt_arbiter.
// Expectations follow FIFO_ARB_PKT_LOCK_EN (packet lock) or its absence (flit round robin).
module tb_fifo_pkt_arbiter;
    localparam int NP = 4;
    localparam int W  = 36;
`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [0:3][3:0] n;
        logic [3:0]      cnt;
        logic [0:5][1:0] port;
        logic [0:5][1:0] gap;
    } vec_t;

    logic clk = 1'b0, preset_full = 1'b1, clr = 1'b1, auto_ret = 1'b0, man_ret = 1'b0;
    logic i_credit_return, o_valid, o_busy;
    logic [NP-1:0] f_empty, f_almost_empty, f_next_is_tail, f_read_en, o_grant;
    logic [NP*W-1:0] f_data;
    logic [W-1:0] o_data;

    logic [W-1:0] mem [NP][64];
    logic [W-1:0] fd [NP] = '{default: '0};
    int wr [NP] = '{default: 0};
    int rd [NP] = '{default: 0};
    logic [W-1:0] exp_q [$];
    int pop_port [$], pop_cyc [$];
    int cyc = 0, seq = 0, n_pass = 0, n_total = 0;
    vec_t tv [4];

    fifo_pkt_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .CREDITS(8)) dut (
        .clk(clk), .preset_full(preset_full), .f_empty(f_empty), .f_almost_empty(f_almost_empty),
        .f_next_is_tail(f_next_is_tail), .f_data(f_data), .f_read_en(f_read_en),
        .i_credit_return(i_credit_return), .o_data(o_data), .o_valid(o_valid),
        .o_grant(o_grant), .o_busy(o_busy));

    assign i_credit_return = man_ret | (auto_ret & o_valid);
    always #5 clk = ~clk;

    always_comb begin
        f_data = '0;
        for (int p = 0; p < NP; p++) begin
            f_empty[p]        = rd[p] == wr[p];
            f_almost_empty[p] = wr[p] - rd[p] <= 1;
            f_next_is_tail[p] = mem[p][rd[p] % 64][W-3];
            f_data[p*W +: W]  = fd[p];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int p = 0; p < NP; p++) begin
            if (f_read_en[p]) begin
                rd[p] <= rd[p] + 1;
                fd[p] <= mem[p][rd[p] % 64];
                pop_port.push_back(p);
                pop_cyc.push_back(cyc);
                exp_q.push_back(mem[p][rd[p] % 64]);
            end
            if (clr) rd[p] <= wr[p];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL o_valid: got flit %0h expected no output", o_data);
            end else chk("o_data", o_data, exp_q.pop_front());
        end
        if (|f_read_en)
            chk("pop_legal", $countones(f_read_en) == 1 && (f_read_en & (f_empty | ~o_grant)) == '0, 1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push_flit(input int p, input logic h, input logic t);
        mem[p][wr[p] % 64] = {1'b1, h, t, 33'(seq)};
        seq++;
        wr[p]++;
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int k = 0; k < len; k++) push_flit(p, k == 0, k == len - 1);
    endtask

    task automatic wait_pops(input int tgt, input int budget);
        int k = 0;
        while (pop_port.size() < tgt && k < budget) begin tick(); k++; end
        if (pop_port.size() < tgt) chk("pop_timeout", pop_port.size(), tgt);
    endtask

    task automatic run_vec(input vec_t v);
        int b = pop_port.size();
        for (int p = 0; p < NP; p++) push_pkt(p, int'(v.n[p]));
        wait_pops(b + int'(v.cnt), 200);
        for (int i = 0; i < int'(v.cnt); i++) begin
            chk("pop_port", pop_port[b+i], v.port[i]);
            if (i > 0) chk("pop_gap", pop_cyc[b+i] - pop_cyc[b+i-1], v.gap[i]);
        end
        tick(3);
        chk("idle_busy", o_busy, 0);
        chk("idle_grant", o_grant, 0);
    endtask

    initial begin
        int b, rt;
        tv[0] = '{n: {4'd3, 4'd0, 4'd0, 4'd0}, cnt: 4'd3, port: '0,
                  gap: LOCK ? {2'd0, 2'd1, 2'd1, 6'd0} : {2'd0, 2'd2, 2'd2, 6'd0}};
        tv[1] = '{n: {4'd0, 4'd2, 4'd2, 4'd0}, cnt: 4'd4,
                  port: LOCK ? {2'd1, 2'd1, 2'd2, 2'd2, 4'd0} : {2'd1, 2'd2, 2'd1, 2'd2, 4'd0},
                  gap: LOCK ? {2'd0, 2'd1, 2'd2, 2'd1, 4'd0} : {2'd0, 2'd2, 2'd2, 2'd2, 4'd0}};
        tv[2] = '{n: {4'd1, 4'd1, 4'd0, 4'd0}, cnt: 4'd2, port: {2'd0, 2'd1, 8'd0}, gap: {2'd0, 2'd2, 8'd0}};
        tv[3] = '{n: {4'd2, 4'd2, 4'd0, 4'd0}, cnt: 4'd4,
                  port: LOCK ? {2'd0, 2'd0, 2'd1, 2'd1, 4'd0} : {2'd0, 2'd1, 2'd0, 2'd1, 4'd0},
                  gap: LOCK ? {2'd0, 2'd1, 2'd2, 2'd1, 4'd0} : {2'd0, 2'd2, 2'd2, 2'd2, 4'd0}};
        tick(3);
        chk("rst_read_en", f_read_en, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_busy", o_busy, 0);
        preset_full = 1'b0;
        clr = 1'b0;
        tick(2);
        // Credits 8 -> 5 -> 1 across the first two vectors; no returns yet.
        run_vec(tv[0]);
        run_vec(tv[1]);
        b = pop_port.size();
        push_pkt(3, 4);
        wait_pops(b + 1, 50);
        tick(6);
        chk("credit_stall_pops", pop_port.size() - b, 1);
        chk("credit_stall_grant", o_grant, 4'b1000);
        chk("credit_stall_busy", o_busy, 1);
        man_ret = 1'b1;
        rt = cyc;
        tick(2);
        man_ret = 1'b0;
        wait_pops(b + 3, 20);
        chk("credit_ret_pop", pop_cyc[b+1], rt + 1);
        chk("credit_coincident_pop", pop_cyc[b+2], rt + (LOCK ? 2 : 3));
        tick(6);
        chk("credit_exhausted_pops", pop_port.size() - b, 3);
        man_ret = 1'b1;
        tick(10);
        man_ret = 1'b0;
        chk("tail_after_ret", pop_port.size() - b, 4);
        tick(2);
        b = pop_port.size();
        push_pkt(0, 10);
        tick(40);
        chk("credit_saturate_pops", pop_port.size() - b, 8);
        chk("credit_saturate_grant", o_grant, 4'b0001);
        preset_full = 1'b1;
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        preset_full = 1'b0;
        tick(2);
        b = pop_port.size();
        push_pkt(2, 4);
        wait_pops(b + 1, 20);
        for (int k = 0; k < 5 && !f_read_en[2]; k++) tick();
        @(negedge clk);
        #1 preset_full = 1'b1;
        #1;
        chk("mid_rst_read_en", f_read_en, 0);
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_grant", o_grant, 0);
        chk("mid_rst_busy", o_busy, 0);
        tick();
        clr = 1'b1;
        tick(2);
        clr = 1'b0;
        preset_full = 1'b0;
        chk("mid_rst_pops", pop_port.size() - b, 1);
        auto_ret = 1'b1;
        run_vec(tv[2]);
        run_vec(tv[3]);
        b = pop_port.size();
        push_flit(0, 1'b1, 1'b0);
        wait_pops(b + 1, 20);
        push_pkt(3, 2);
        chk("split_first", pop_port[b], 0);
`ifdef FIFO_ARB_PKT_LOCK_EN
        tick(4);
        chk("split_stall_pops", pop_port.size() - b, 1);
        chk("split_stall_grant", o_grant, 4'b0001);
        chk("split_stall_busy", o_busy, 1);
        push_flit(0, 1'b0, 1'b1);
        wait_pops(b + 4, 30);
        chk("split_second", pop_port[b+1], 0);
        chk("split_then3a", pop_port[b+2], 3);
        chk("split_then3b", pop_port[b+3], 3);
`else
        wait_pops(b + 3, 30);
        chk("flit_other_a", pop_port[b+1], 3);
        chk("flit_other_b", pop_port[b+2], 3);
        push_flit(0, 1'b0, 1'b1);
        wait_pops(b + 4, 30);
        chk("flit_back0", pop_port[b+3], 0);
`endif
        tick(3);
        b = pop_port.size();
        push_flit(0, 1'b1, 1'b0);
        wait_pops(b + 1, 20);
        push_flit(0, 1'b0, 1'b1);
        wait_pops(b + 2, 20);
        chk("bubble_port", pop_port[b], 0);
        chk("bubble_gap", pop_cyc[b+1] - pop_cyc[b], 2);
        tick(4);
        chk("end_scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
